// File: rtl/sc_io_pkg.sv
// rtl/sc_io_pkg.sv - shared decode constants for the data-side memory/IO responder
// IO page base, register offsets and STATUS bit positions.
package sc_io_pkg;

   localparam logic [7:0] IO_PAGE    = 8'hFF;

   localparam logic [7:0] OFF_SW     = 8'h00;
   localparam logic [7:0] OFF_TIMER  = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h08;
   localparam logic [7:0] OFF_FIFO   = 8'h0C;

   localparam int ST_EXPIRED   = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_COUNT_W   = 3;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - output word FIFO with valid/ready head toward the display consumer
// Head is driven purely from stored state; a push to a full FIFO is accepted only alongside a pop.
module io_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic [31:0]        wdata,
   output logic               full,
   output logic [FIFO_AW:0]   count,
   output logic               out_valid,
   output logic [31:0]        out_data,
   input  logic               out_ready,
   output logic               overflow
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [31:0]      mem_q [DEPTH];
   logic [FIFO_AW:0] wptr_q, wptr_d;
   logic [FIFO_AW:0] rptr_q, rptr_d;
   logic             pop, accept;

   assign count     = wptr_q - rptr_q;
   assign full      = (count == (FIFO_AW + 1)'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem_q[rptr_q[FIFO_AW-1:0]];

   assign pop      = out_valid & out_ready;
   assign accept   = push & (~full | pop);
   assign overflow = push & full & ~pop;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (accept) wptr_d = wptr_q + 1'b1;
      if (pop)    rptr_d = rptr_q + 1'b1;
   end

   // Storage is cleared too so the head word reads 0 straight out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (accept) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/sc_dmem_io.sv
// rtl/sc_dmem_io.sv - single-cycle CPU data port: word RAM plus memory-mapped IO page
// Combinational read path; RAM, reload timer, sticky status and output FIFO update on the clock edge.
module sc_dmem_io
   import sc_io_pkg::*;
#(
   parameter int RAM_AW  = 6,
   parameter int FIFO_AW = 2,
   parameter int SW_W    = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   input  logic            we,
   output logic [31:0]     rdata,
   input  logic [SW_W-1:0] sw,
   output logic            out_valid,
   output logic [31:0]     out_data,
   input  logic            out_ready
);

   logic [31:0]       ram_q [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_sel, io_sel;
   logic [7:0]        off;

   logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
   logic [31:0]       cnt_q, cnt_d, reload_q, reload_d;
   logic              expired_q, expired_d, overflow_q, overflow_d;
   logic              tmr_wr, stat_wr, fifo_push, exp_set;

   logic              fifo_full, fifo_ovf;
   logic [FIFO_AW:0]  fifo_count;
   logic [31:0]       status;

   assign ram_sel = (addr[31:8] == 24'h0);
   assign io_sel  = (addr[31:16] == 16'h0) && (addr[15:8] == IO_PAGE);
   assign ram_idx = addr[RAM_AW+1:2];
   assign off     = addr[7:0];

   assign tmr_wr    = we & io_sel & (off == OFF_TIMER);
   assign stat_wr   = we & io_sel & (off == OFF_STATUS);
   assign fifo_push = we & io_sel & (off == OFF_FIFO);

   always_ff @(posedge clock) begin
      if (we && ram_sel) ram_q[ram_idx] <= wdata;
   end

   io_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .wdata     (wdata),
      .full      (fifo_full),
      .count     (fifo_count),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .overflow  (fifo_ovf)
   );

   // A TIMER write pre-empts the reload, so it never raises expired itself.
   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      exp_set  = 1'b0;
      if (tmr_wr) begin
         cnt_d    = wdata;
         reload_d = wdata;
      end else if (cnt_q == 32'd1) begin
         exp_set = 1'b1;
         cnt_d   = reload_q;
      end else if (cnt_q != 32'd0) begin
         cnt_d = cnt_q - 32'd1;
      end
      expired_d  = exp_set  | (expired_q  & ~(stat_wr & wdata[ST_EXPIRED]));
      overflow_d = fifo_ovf | (overflow_q & ~(stat_wr & wdata[ST_OVERFLOW]));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         cnt_q      <= '0;
         reload_q   <= '0;
         expired_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         cnt_q      <= cnt_d;
         reload_q   <= reload_d;
         expired_q  <= expired_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      status                                = '0;
      status[ST_EXPIRED]                    = expired_q;
      status[ST_FULL]                       = fifo_full;
      status[ST_EMPTY]                      = ~out_valid;
      status[ST_OVERFLOW]                   = overflow_q;
      status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      if (ram_sel) begin
         rdata = ram_q[ram_idx];
      end else if (io_sel) begin
         case (off)
            OFF_SW:     rdata = 32'(sw_sync_q);
            OFF_TIMER:  rdata = cnt_q;
            OFF_STATUS: rdata = status;
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sc_dmem_io.sv
// tb/tb_sc_dmem_io.sv - self-checking bench for sc_dmem_io with a FIFO scoreboard
// Main thread drives CPU accesses; a negedge monitor models and checks the FIFO head.
module tb_sc_dmem_io;

   localparam logic [31:0] SW_A   = 32'h0000FF00;
   localparam logic [31:0] TMR_A  = 32'h0000FF04;
   localparam logic [31:0] STAT_A = 32'h0000FF08;
   localparam logic [31:0] FIFO_A = 32'h0000FF0C;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic        we    = 1'b0;
   logic [15:0] sw    = '0;
   logic        out_ready = 1'b0;
   logic [31:0] rdata;
   logic        out_valid;
   logic [31:0] out_data;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] q[$];
   logic        ov_m = 1'b0;

   sc_dmem_io #(.RAM_AW(6), .FIFO_AW(2), .SW_W(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .we        (we),
      .rdata     (rdata),
      .sw        (sw),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #20 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      we   = 1'b0;
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   function automatic logic [31:0] stat_exp(input logic e);
      return {25'b0, 3'(q.size()), ov_m, q.size() == 0, q.size() == 4, e};
   endfunction

   // FIFO reference model: checked and advanced just before each active edge.
   always @(negedge clock) begin
      logic pop_m, psh, acc;
      if (!reset) begin
         check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
         if (q.size() != 0) check("out_data", out_data, q[0]);
         pop_m = (q.size() != 0) && out_ready;
         psh   = we && (addr == FIFO_A);
         acc   = psh && ((q.size() < 4) || pop_m);
         if (we && (addr == STAT_A) && wdata[3]) ov_m = 1'b0;
         if (psh && !acc) ov_m = 1'b1;
         if (pop_m) void'(q.pop_front());
         if (acc) q.push_back(wdata);
      end
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_data", out_data, 32'h0);
      rd_chk("rst_timer", TMR_A, 32'h0);
      rd_chk("rst_status", STAT_A, 32'h4);
      rd_chk("rst_sw", SW_A, 32'h0);
      reset = 1'b0;
      tick();

      wr(32'h10, 32'hDEADBEEF);
      wr(32'h14, 32'h1);
      wr(32'h00, 32'h11111111);
      rd_chk("ram_10", 32'h10, 32'hDEADBEEF);
      rd_chk("ram_13", 32'h13, 32'hDEADBEEF);
      rd_chk("ram_14", 32'h14, 32'h1);
      rd_chk("unmapped_100", 32'h100, 32'h0);
      wr(32'h100, 32'h12345678);
      rd_chk("ram_0_after_100", 32'h00, 32'h11111111);
      rd_chk("ram_10_after_100", 32'h10, 32'hDEADBEEF);
      addr = 32'h10; wdata = 32'h0000CAFE; we = 1'b1;
      #1;
      check("ram_read_old", rdata, 32'hDEADBEEF);
      tick();
      we = 1'b0;
      rd_chk("ram_read_new", 32'h10, 32'h0000CAFE);

      wr(TMR_A, 32'd3);
      rd_chk("timer_3", TMR_A, 32'd3);
      tick();
      rd_chk("timer_2", TMR_A, 32'd2);
      tick();
      rd_chk("timer_1", TMR_A, 32'd1);
      wr(STAT_A, 32'h1);
      rd_chk("expired_set_wins", STAT_A, 32'h5);
      rd_chk("timer_reload", TMR_A, 32'd3);
      wr(STAT_A, 32'h1);
      rd_chk("expired_cleared", STAT_A, 32'h4);
      rd_chk("timer_after_clr", TMR_A, 32'd2);
      wr(TMR_A, 32'd0);
      tick();
      rd_chk("timer_stopped", TMR_A, 32'd0);

      out_ready = 1'b0;
      for (int v = 32'hA; v <= 32'hE; v++) wr(FIFO_A, 32'(v));
      rd_chk("stat_overflow", STAT_A, stat_exp(1'b0));
      rd_chk("stat_overflow_abs", STAT_A, 32'h4A);
      out_ready = 1'b1;
      repeat (6) tick();
      check("drained_valid", {31'b0, out_valid}, 32'h0);
      rd_chk("stat_drained", STAT_A, 32'h0C);
      wr(STAT_A, 32'h8);
      rd_chk("stat_ovf_clr", STAT_A, 32'h4);

      out_ready = 1'b0;
      for (int v = 1; v <= 4; v++) wr(FIFO_A, 32'(v));
      out_ready = 1'b1;
      wr(FIFO_A, 32'hF);
      rd_chk("stat_push_pop_full", STAT_A, stat_exp(1'b0));
      rd_chk("stat_push_pop_abs", STAT_A, 32'h42);
      repeat (6) tick();
      check("drained2_valid", {31'b0, out_valid}, 32'h0);

      rd_chk("fifo_reg_read", FIFO_A, 32'h0);
      rd_chk("undef_offset", 32'h0000FF10, 32'h0);
      rd_chk("unmapped_high", 32'h00010010, 32'h0);
      rd_chk("unmapped_fe", 32'h0000FE00, 32'h0);

      sw = 16'h5A5A;
      rd_chk("sw_cyc1", SW_A, 32'h0);
      tick();
      rd_chk("sw_cyc2", SW_A, 32'h0);
      tick();
      rd_chk("sw_cyc3", SW_A, 32'h00005A5A);

      out_ready = 1'b0;
      wr(FIFO_A, 32'h21);
      wr(FIFO_A, 32'h22);
      wr(TMR_A, 32'd100);
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_valid", {31'b0, out_valid}, 32'h0);
      q.delete();
      ov_m = 1'b0;
      rd_chk("rst_mid_timer", TMR_A, 32'h0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      rd_chk("post_rst_timer", TMR_A, 32'h0);
      rd_chk("post_rst_status", STAT_A, 32'h4);
      rd_chk("post_rst_ram10", 32'h10, 32'h0000CAFE);
      rd_chk("post_rst_ram14", 32'h14, 32'h1);
      rd_chk("post_rst_ram0", 32'h00, 32'h11111111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
